// File: rtl/prbs_checker.sv
// Self-synchronising serial checker for an 8-bit Fibonacci LFSR stream.
// Locks onto the received sequence, then free-runs and counts bit errors.
module prbs_checker #(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       tap,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int unsigned FILL_W  = 4;
    localparam int unsigned FILL_N  = 8;
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(UNLOCK_CNT + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic [7:0]         chk_q,       chk_d;
    logic [FILL_W-1:0]  fill_q,      fill_d;
    logic [MATCH_W-1:0] match_q,     match_d;
    logic [MISS_W-1:0]  miss_q,      miss_d;
    logic               locked_q,    locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic               pred_c;
    logic               filled_c;

    assign pred_c   = ^(chk_q & tap);
    assign filled_c = (fill_q == FILL_W'(FILL_N));

    // Next-state: search/fill/match while hunting, free-run and count once locked.
    always_comb begin
        state_d     = state_q;
        chk_d       = chk_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;

        if (bit_valid) begin
            if (state_q == SEARCH) begin
                chk_d = {chk_q[6:0], bit_in};
                if (!filled_c) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                if (filled_c && (bit_in == pred_c)) begin
                    if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        match_d  = '0;
                        miss_d   = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                // Shift in the prediction so one flipped bit costs exactly one error.
                chk_d = {chk_q[6:0], pred_c};
                if (bit_cnt_q != {CNT_W{1'b1}}) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                if (bit_in != pred_c) begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (miss_q == MISS_W'(UNLOCK_CNT - 1)) begin
                        state_d  = SEARCH;
                        locked_d = 1'b0;
                        fill_d   = '0;
                        match_d  = '0;
                        miss_d   = '0;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end else begin
                    miss_d = '0;
                end
            end
        end

        if (clear_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= SEARCH;
            chk_q       <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            chk_q       <= chk_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, gaps, errors, unlock, clear and saturation.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  tap;
    logic        bit_in;
    logic        bit_valid;
    logic        clear_cnt;
    logic        locked, err_pulse;
    logic [15:0] err_cnt, bit_cnt;
    logic        locked2, err_pulse2;
    logic [3:0]  err_cnt2, bit_cnt2;

    logic [7:0]  gen;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .resetn(resetn), .tap(tap), .bit_in(bit_in),
        .bit_valid(bit_valid), .clear_cnt(clear_cnt), .locked(locked),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    prbs_checker #(.LOCK_CNT(16), .UNLOCK_CNT(32), .CNT_W(4)) dut_sat (
        .clk(clk), .resetn(resetn), .tap(tap), .bit_in(bit_in),
        .bit_valid(bit_valid), .clear_cnt(clear_cnt), .locked(locked2),
        .err_pulse(err_pulse2), .err_cnt(err_cnt2), .bit_cnt(bit_cnt2)
    );

    // Drive one cycle; outputs are sampled 1ns after the edge that consumed it.
    task automatic step(input logic b, input logic v, input logic clr);
        bit_in    = b;
        bit_valid = v;
        clear_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic gen_next();
        logic b;
        b   = ^(gen & tap);
        gen = {gen[6:0], b};
        return b;
    endfunction

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) step(gen_next(), 1'b1, 1'b0);
    endtask

    task automatic send_inv(input int n);
        for (int i = 0; i < n; i++) step(~gen_next(), 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        gen    = 8'h01;
    endtask

    task automatic test_reset();
        tap = 8'hB8;
        do_reset();
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_cnt !== 16'd0 || bit_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: locked=%b pulse=%b err=%0d bits=%0d, want all 0", locked, err_pulse, err_cnt, bit_cnt);
        end
    endtask

    task automatic test_lock();
        do_reset();
        send_clean(23);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock_early: locked=%b want 0 after 23 bits", locked); end
        send_clean(1);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL lock_24: locked=%b want 1 after 24 bits", locked); end
        send_clean(10);
        checks++;
        if (err_cnt !== 16'd0 || bit_cnt !== 16'd10) begin
            failures++;
            $display("FAIL lock_counts: err=%0d bits=%0d want err=0 bits=10", err_cnt, bit_cnt);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int i = 0; i < 23; i++) begin
            send_clean(1);
            step(1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL gaps_early: locked=%b want 0", locked); end
        send_clean(1);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL gaps_lock: locked=%b want 1", locked); end
        send_clean(1);
        step(~gen[0], 1'b0, 1'b0);
        checks++;
        if (bit_cnt !== 16'd1 || err_cnt !== 16'd0 || err_pulse !== 1'b0) begin
            failures++;
            $display("FAIL gaps_idle: bits=%0d err=%0d pulse=%b want 1/0/0", bit_cnt, err_cnt, err_pulse);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        send_clean(24);
        send_clean(5);
        send_inv(1);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL single_err: pulse=%b err=%0d locked=%b want 1/1/1", err_pulse, err_cnt, locked);
        end
        send_clean(1);
        checks++;
        if (err_pulse !== 1'b0) begin failures++; $display("FAIL single_pulse_width: pulse=%b want 0", err_pulse); end
        send_clean(10);
        checks++;
        if (err_cnt !== 16'd1 || bit_cnt !== 16'd17) begin
            failures++;
            $display("FAIL single_after: err=%0d bits=%0d want 1/17", err_cnt, bit_cnt);
        end
    endtask

    // Continues from test_single_error: err_cnt=1, bit_cnt=17, locked.
    task automatic test_loss_of_lock();
        send_inv(7);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd8) begin
            failures++;
            $display("FAIL unlock_7: locked=%b err=%0d want 1/8", locked, err_cnt);
        end
        send_inv(1);
        checks++;
        if (locked !== 1'b0 || err_cnt !== 16'd9 || bit_cnt !== 16'd25) begin
            failures++;
            $display("FAIL unlock_8: locked=%b err=%0d bits=%0d want 0/9/25", locked, err_cnt, bit_cnt);
        end
        send_clean(23);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL relock_early: locked=%b want 0", locked); end
        send_clean(1);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd9 || bit_cnt !== 16'd25) begin
            failures++;
            $display("FAIL relock: locked=%b err=%0d bits=%0d want 1/9/25", locked, err_cnt, bit_cnt);
        end
    endtask

    task automatic test_clear_collision();
        step(~gen_next(), 1'b1, 1'b1);
        checks++;
        if (err_cnt !== 16'd0 || bit_cnt !== 16'd0 || err_pulse !== 1'b1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL clear_collide: err=%0d bits=%0d pulse=%b locked=%b want 0/0/1/1", err_cnt, bit_cnt, err_pulse, locked);
        end
        send_clean(1);
        send_inv(1);
        checks++;
        if (err_cnt !== 16'd1 || bit_cnt !== 16'd2) begin
            failures++;
            $display("FAIL clear_next: err=%0d bits=%0d want 1/2", err_cnt, bit_cnt);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (err_cnt !== 16'd0 || bit_cnt !== 16'd0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL clear_idle: err=%0d bits=%0d locked=%b want 0/0/1", err_cnt, bit_cnt, locked);
        end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        send_clean(24);
        checks++;
        if (locked2 !== 1'b1) begin failures++; $display("FAIL sat_lock: locked=%b want 1", locked2); end
        send_inv(20);
        checks++;
        if (err_cnt2 !== 4'd15 || bit_cnt2 !== 4'd15 || locked2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_cnt: err=%0d bits=%0d locked=%b want 15/15/1", err_cnt2, bit_cnt2, locked2);
        end
        resetn = 1'b0;
        step(~gen_next(), 1'b1, 1'b0);
        resetn = 1'b1;
        checks++;
        if (locked2 !== 1'b0 || err_cnt2 !== 4'd0 || bit_cnt2 !== 4'd0 || err_pulse2 !== 1'b0) begin
            failures++;
            $display("FAIL sat_reset: locked=%b err=%0d bits=%0d pulse=%b want all 0", locked2, err_cnt2, bit_cnt2, err_pulse2);
        end
    endtask

    task automatic test_degenerate();
        tap = 8'h00;
        do_reset();
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL degen_lock: locked=%b want 1", locked); end
        tap = 8'hB8;
    endtask

    initial begin
        resetn    = 1'b0;
        tap       = 8'hB8;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clear_cnt = 1'b0;
        gen       = 8'h01;
        test_reset();
        test_lock();
        test_gaps();
        test_single_error();
        test_loss_of_lock();
        test_clear_collision();
        test_saturation_reset();
        test_degenerate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial checker downstream of the 8-bit Fibonacci LFSR generator; consumes the newly generated bit (generator dout[0]) each valid cycle.
- Self-synchronises to the received stream, then free-runs its own LFSR copy and counts bit errors.
- Used for link/loopback BIST: lock status and error statistics go to the CSR block.

Parameters:
- LOCK_CNT, 16, consecutive predicted-bit matches needed to declare lock (after 8-bit fill).
- UNLOCK_CNT, 8, consecutive mismatches in LOCKED that force return to SEARCH.
- CNT_W, 16, width of err_cnt and bit_cnt.

Ports:
- clk  input  1  single clock; all logic on posedge.
- resetn  input  1  synchronous, active-low reset.
- tap  input  8  feedback polynomial mask; same value as the generator's tap; must be static while checking.
- bit_in  input  1  received serial bit.
- bit_valid  input  1  bit_in qualifier; the block ignores bit_in when low.
- clear_cnt  input  1  synchronous clear of err_cnt and bit_cnt.
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle strobe, registered, for each mismatching bit while LOCKED.
- err_cnt  output  CNT_W  saturating count of mismatches while LOCKED.
- bit_cnt  output  CNT_W  saturating count of bits checked while LOCKED.

Behaviour:
- Reset (resetn=0 at a posedge) has these effects:
  - state=SEARCH; chk=0; fill_cnt=0; match_cnt=0; miss_run=0.
  - locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
  - Reset mid-lock drops locked on that same edge.
- Prediction: pred = ^(chk & tap). chk[0] is the most recent bit, which matches the generator's left-shift ordering.
- bit_valid=0: no register changes, except err_pulse is 0 and clear_cnt is still honoured.
- SEARCH, per valid bit:
  - chk <= {chk[6:0], bit_in}.
  - fill_cnt increments and saturates at 8.
  - If fill_cnt==8 and bit_in==pred, match_cnt++; otherwise match_cnt=0.
  - When a match brings match_cnt to LOCK_CNT: state<=LOCKED, locked=1 from the next cycle. That is on the (8+LOCK_CNT)th valid bit of a clean stream.
  - Nothing is counted in SEARCH; err_pulse=0.
- LOCKED, per valid bit:
  - chk <= {chk[6:0], pred}. The checker free-runs, so a single flipped bit counts as exactly one error.
  - bit_cnt++.
  - If bit_in!=pred: err_pulse=1 the next cycle, err_cnt++, miss_run++. Otherwise miss_run=0.
  - When a mismatch brings miss_run to UNLOCK_CNT: state<=SEARCH; locked=0 next cycle; fill_cnt, match_cnt and miss_run=0. err_cnt/bit_cnt still count that final bit.
- Counters saturate at all-ones and do not wrap.
- clear_cnt:
  - Zeroes err_cnt and bit_cnt at the edge.
  - Has priority over a simultaneous increment; that bit is not counted.
  - err_pulse is still asserted for it.
  - Does not affect state or lock.
- Degenerate streams:
  - An all-zero stream, or tap=0, predicts 0 forever and will lock. This is required behaviour; software checks bit_cnt progress and generator seed.
- Latency: err_pulse and counter updates appear 1 cycle after the offending valid bit.

Test Plan:
- Lock: tap=8'hB8; generator seeded 8'h01 feeds bit_in with bit_valid=1 continuously -> locked rises exactly 1 cycle after the 24th valid bit; err_cnt=0; bit_cnt=N-24 after N bits.
- Gaps: same stream with bit_valid toggling 1/0 every cycle -> lock after 24 valid bits (48 cycles); no count changes on invalid cycles.
- Single error: while locked, invert one bit -> err_pulse high for exactly 1 cycle, err_cnt=1, locked stays 1; subsequent clean bits add no errors.
- Loss of lock: while locked, feed inverted stream -> err_cnt increases by 8; locked falls 1 cycle after 8th inverted bit. Restore clean stream -> relock after 24 more valid bits; err_cnt held at 8.
- Clear collision: assert clear_cnt in the same cycle as an injected error -> err_cnt=0, bit_cnt=0, err_pulse=1 next cycle; next error gives err_cnt=1.
- Saturation/reset: CNT_W=4, continuous inverted bits with UNLOCK_CNT=32 -> err_cnt sticks at 15. Pulse resetn low for one edge mid-lock -> locked=0 and all counters 0 on that edge.
